// File: rtl/mips_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory boot loader.
// Ports: none (package).
// The trailing-checksum option is controlled by the IMEM_BOOT_CSUM_EN macro in the loader top.
package mips_pkg;

   localparam int          IMEM_ADDR_W   = 10;
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'h55;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT_HI,
      ST_CNT_LO,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Ports: rx_data/rx_valid/rx_ready byte handshake; imem_we/imem_addr/imem_wdata word write.
// master = byte source / memory side, slave = loader side.
interface imem_boot_loader_if
   import mips_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader_word.sv
// Assembles four accepted bytes into one big-endian 32-bit word.
// Ports: clk, reset, clear (restart at byte 0), byte_valid/byte_data in; word_valid/word_data out.
// word_valid is combinational and coincides with acceptance of the 4th byte.
module boot_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word_data
);
   logic [23:0] shift;
   logic [1:0]  byte_cnt;

   // The first byte of a word ends up in bits [31:24].
   assign word_data  = {shift, byte_data};
   assign word_valid = byte_valid && (byte_cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         shift    <= '0;
         byte_cnt <= '0;
      end else if (byte_valid) begin
         shift    <= {shift[15:0], byte_data};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end
endmodule

// File: rtl/imem_boot_loader.sv
// Serial-byte boot loader: parses SYNC, 16-bit word count, data words (and an optional XOR
// checksum when IMEM_BOOT_CSUM_EN is defined), writes imem one word per strobe, holds cpu_reset.
// Ports: clk, reset (sync, active-high), bus (slave: byte in, imem write out), cpu_reset, boot_done, boot_err.
module imem_boot_loader
   import mips_pkg::*;
#(
   parameter int         ADDR_W    = IMEM_ADDR_W,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   imem_boot_loader_if.slave   bus,
   output logic                cpu_reset,
   output logic                boot_done,
   output logic                boot_err
);
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
`ifdef IMEM_BOOT_CSUM_EN
   localparam boot_state_t AFTER_DATA = ST_CSUM;
`else
   localparam boot_state_t AFTER_DATA = ST_DONE;
`endif

   boot_state_t state, state_next;
   logic        rx_ready;
   logic        accept;
   logic        is_sync;
   logic [7:0]  cnt_hi;
   logic [15:0] count_rx;
   logic [15:0] n_words;
   logic [15:0] word_idx;
   logic        last_word;
   logic        word_valid;
   logic [31:0] word_data;

   assign rx_ready     = (state != ST_ERR);
   assign bus.rx_ready = rx_ready;
   assign accept       = bus.rx_valid && rx_ready;
   assign is_sync      = (bus.rx_data == SYNC_BYTE);
   assign count_rx     = {cnt_hi, bus.rx_data};
   assign last_word    = (word_idx == n_words - 16'd1);

   assign boot_done = (state == ST_DONE);
   assign boot_err  = (state == ST_ERR);
   // Without a checksum, DONE is entered alongside the final write strobe; keep the core
   // in reset through that cycle so it is released one cycle after the last write.
   assign cpu_reset = (state != ST_DONE) || bus.imem_we;

   boot_word_assembler u_word (
      .clk        (clk),
      .reset      (reset),
      .clear      (state == ST_CNT_LO),
      .byte_valid (accept && (state == ST_DATA)),
      .byte_data  (bus.rx_data),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

`ifdef IMEM_BOOT_CSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk) begin
      if (reset) begin
         csum <= '0;
      end else if (accept) begin
         if ((state == ST_IDLE || state == ST_DONE) && is_sync) begin
            csum <= '0;
         end else if (state == ST_CNT_HI || state == ST_CNT_LO || state == ST_DATA) begin
            csum <= csum ^ bus.rx_data;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept && is_sync) state_next = ST_CNT_HI;
         ST_CNT_HI: if (accept) state_next = ST_CNT_LO;
         ST_CNT_LO: begin
            if (accept) begin
               if ({1'b0, count_rx} > MAX_WORDS) state_next = ST_ERR;
               else if (count_rx == 16'd0)       state_next = AFTER_DATA;
               else                              state_next = ST_DATA;
            end
         end
         ST_DATA:   if (word_valid && last_word) state_next = AFTER_DATA;
`ifdef IMEM_BOOT_CSUM_EN
         ST_CSUM: begin
            if (accept) state_next = (bus.rx_data == csum) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE:   if (accept && is_sync) state_next = ST_CNT_HI;
         ST_ERR:    state_next = ST_ERR;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Write strobe is registered one cycle behind the 4th byte; the next word needs four
   // more bytes, so a strobe can never be pending when another word completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_hi         <= '0;
         n_words        <= '0;
         word_idx       <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
      end else begin
         bus.imem_we <= word_valid;
         if (word_valid) begin
            bus.imem_addr  <= word_idx[ADDR_W-1:0];
            bus.imem_wdata <= word_data;
            word_idx       <= word_idx + 16'd1;
         end
         if (accept && state == ST_CNT_HI) cnt_hi <= bus.rx_data;
         if (accept && state == ST_CNT_LO) begin
            n_words  <= count_rx;
            word_idx <= '0;
         end
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frame table plus hand-written mid-load reset
// and restart-from-DONE sequences; expected writes go through a scoreboard queue.
// Works with IMEM_BOOT_CSUM_EN defined or undefined.
module tb_imem_boot_loader;
`ifdef IMEM_BOOT_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cpu_reset, boot_done, boot_err;

   imem_boot_loader_if #(.ADDR_W(10)) bus ();

   imem_boot_loader #(.ADDR_W(10), .SYNC_BYTE(8'h55)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .cpu_reset (cpu_reset),
      .boot_done (boot_done),
      .boot_err  (boot_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string        name;
      int           len;
      logic [159:0] bytes_p;   // last byte in the low bits
      int           skip;      // index of the SYNC byte
      int           gap;       // idle cycles after each byte
      int           nw;
      logic [127:0] words_p;   // last word in the low bits
      bit           bad_csum;
      bit           exp_done;
      bit           exp_err;
   } vec_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  n_writes = 0;
   int  last_we_cyc = 0;
   int  fall_cyc = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor / scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_t e;
         n_writes++;
         last_we_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h/%h required=none", bus.imem_addr, bus.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
            check("wr_data", bus.imem_wdata, e.data);
         end
      end
      if (cpu_reset === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
   end

   function automatic vec_t mk(input string name, input int len, input logic [159:0] b, input int skip,
                               input int gap, input int nw, input logic [127:0] w, input bit bad,
                               input bit done, input bit err);
      vec_t v;
      v.name = name; v.len = len; v.bytes_p = b; v.skip = skip; v.gap = gap;
      v.nw = nw; v.words_p = w; v.bad_csum = bad; v.exp_done = done; v.exp_err = err;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      fall_cyc = -1;
      n_writes = 0;
   endtask

   task automatic push_words(input vec_t v);
      wr_t e;
      for (int k = 0; k < v.nw; k++) begin
         e.addr = 10'(k);
         e.data = v.words_p[(v.nw-1-k)*32 +: 32];
         exp_q.push_back(e);
      end
   endtask

   task automatic send_vec(input vec_t v);
      logic [7:0] b;
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < v.len; i++) begin
         b = v.bytes_p[(v.len-1-i)*8 +: 8];
         if (i > v.skip) x = x ^ b;
         send_byte(b, v.gap);
      end
      if (CSUM_ON) send_byte(x ^ {7'd0, v.bad_csum}, v.gap);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".rx_ready"},   32'(bus.rx_ready), 32'd1);
      check({tag, ".imem_we"},    32'(bus.imem_we), 32'd0);
      check({tag, ".imem_addr"},  32'(bus.imem_addr), 32'd0);
      check({tag, ".imem_wdata"}, bus.imem_wdata, 32'd0);
      check({tag, ".cpu_reset"},  32'(cpu_reset), 32'd1);
      check({tag, ".boot_done"},  32'(boot_done), 32'd0);
      check({tag, ".boot_err"},   32'(boot_err), 32'd0);
   endtask

   localparam logic [159:0] BASIC = 160'h55_00_03_20_01_00_0A_20_02_00_14_00_22_18_20;
   localparam logic [127:0] BASIC_W = 128'h2001000A_20020014_00221820;

   vec_t vecs[6];

   initial begin
      bit exp_err, exp_done;
      vecs[0] = mk("basic",       15, BASIC, 0, 0, 3, BASIC_W, 1'b0, 1'b1, 1'b0);
      vecs[1] = mk("garbage_gap", 17, 160'hAA_00_55_00_03_20_01_00_0A_20_02_00_14_00_22_18_20,
                   2, 1, 3, BASIC_W, 1'b0, 1'b1, 1'b0);
      vecs[2] = mk("count_1025",  3, 160'h55_04_01, 0, 0, 0, 128'h0, 1'b0, 1'b0, 1'b1);
      vecs[3] = mk("count_0",     3, 160'h55_00_00, 0, 0, 0, 128'h0, 1'b0, 1'b1, 1'b0);
      vecs[4] = mk("bad_csum",    15, BASIC, 0, 0, 3, BASIC_W, 1'b1, 1'b1, 1'b0);
      vecs[5] = mk("one_word",    7, 160'h55_00_01_AB_CD_EF_01, 0, 0, 1, 128'hABCDEF01, 1'b0, 1'b1, 1'b0);

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      @(posedge clk); #1;
      do_reset();
      check_reset_vals("por");

      foreach (vecs[i]) begin
         do_reset();
         exp_err  = vecs[i].exp_err || (CSUM_ON && vecs[i].bad_csum);
         exp_done = vecs[i].exp_done && !exp_err;
         push_words(vecs[i]);
         send_vec(vecs[i]);
         idle(4);
         check({vecs[i].name, ".boot_done"}, 32'(boot_done), 32'(exp_done));
         check({vecs[i].name, ".boot_err"},  32'(boot_err), 32'(exp_err));
         check({vecs[i].name, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
         check({vecs[i].name, ".rx_ready"},  32'(bus.rx_ready), 32'(!exp_err));
         check({vecs[i].name, ".n_writes"},  32'(n_writes), 32'(vecs[i].nw));
         check({vecs[i].name, ".pending"},   32'(exp_q.size()), 32'd0);
         if (vecs[i].gap == 0 && exp_done && vecs[i].nw > 0)
            check({vecs[i].name, ".release_delay"}, 32'(fall_cyc - last_we_cyc), 32'd1);
         exp_q.delete();
      end

      // Reset after six data bytes: one word written, then everything back to reset values.
      do_reset();
      exp_q.push_back('{addr: 10'd0, data: 32'h2001000A});
      send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
      send_byte(8'h20, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h0A, 0); send_byte(8'h20, 0); send_byte(8'h02, 0);
      check("midload.n_writes", 32'(n_writes), 32'd1);
      check("midload.cpu_reset_held", 32'(cpu_reset), 32'd1);
      do_reset();
      check_reset_vals("midload");
      push_words(vecs[0]);
      send_vec(vecs[0]);
      idle(4);
      check("reload.n_writes",  32'(n_writes), 32'd3);
      check("reload.pending",   32'(exp_q.size()), 32'd0);
      check("reload.boot_done", 32'(boot_done), 32'd1);
      check("reload.cpu_reset", 32'(cpu_reset), 32'd0);

      // SYNC in DONE restarts the load and re-asserts cpu_reset on the next cycle.
      n_writes = 0;
      send_byte(8'h55, 0);
      check("restart.cpu_reset", 32'(cpu_reset), 32'd1);
      check("restart.boot_done", 32'(boot_done), 32'd0);
      exp_q.push_back('{addr: 10'd0, data: 32'hABCDEF01});
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'hEF, 0); send_byte(8'h01, 0);
      if (CSUM_ON) send_byte(8'h89, 0);
      idle(4);
      check("restart.n_writes",  32'(n_writes), 32'd1);
      check("restart.pending",   32'(exp_q.size()), 32'd0);
      check("restart.done",      32'(boot_done), 32'd1);
      check("restart.released",  32'(cpu_reset), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
